// File: rtl/dbg_loader.sv
// dbg_loader: UART byte-stream debug loader that writes words onto the memory bus.
// Optional macro DBG_LOADER_ECHO_EN: ACK echoes 0x06 on tx until accepted.
module dbg_loader #(
  parameter int unsigned WR_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_n_reset,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned WW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [WW-1:0] WR_LAST  = WW'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   oadr_q, oadr_d;
  logic [31:0]   odo_q, odo_d;
  logic          cpu_q, cpu_d;
  logic          ack_done;

`ifdef DBG_LOADER_ECHO_EN
  assign ack_done = tx_ready;
  assign tx_valid = (state_q == S_ACK);
  assign tx_data  = tx_valid ? 8'h06 : 8'h00;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign ack_done = 1'b1;
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    tmo_d   = tmo_q;
    wcnt_d  = wcnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    oadr_d  = oadr_q;
    odo_d   = odo_q;
    cpu_d   = cpu_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            (rx_data == 8'hA5): begin
              state_d = S_ADDR;
              bcnt_d  = '0;
              tmo_d   = '0;
              cpu_d   = 1'b0;
            end
            (rx_data == 8'h5A): begin
              state_d = S_ACK;
              cpu_d   = 1'b1;
            end
            (rx_data == 8'hC3): begin
              state_d = S_ACK;
              cpu_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          // bytes shift in from the top: first byte lands in [7:0]
          tmo_d  = '0;
          bcnt_d = bcnt_q + 2'd1;
          if (state_q == S_ADDR) begin
            adr_d = {rx_data, adr_q[31:8]};
            if (bcnt_q == 2'd3) state_d = S_DATA;
          end else begin
            dat_d = {rx_data, dat_q[31:8]};
            if (bcnt_q == 2'd3) begin
              state_d = S_WRITE;
              wcnt_d  = '0;
              oadr_d  = adr_q;
              odo_d   = {rx_data, dat_q[31:8]};
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (wcnt_q == WR_LAST) begin
          state_d = S_ACK;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ACK: begin
        if (ack_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      wcnt_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      oadr_q  <= '0;
      odo_q   <= '0;
      cpu_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      oadr_q  <= oadr_d;
      odo_q   <= odo_d;
      cpu_q   <= cpu_d;
    end
  end

  assign dbg_mem_op  = (state_q == S_WRITE);
  assign dbg_wren    = {4{dbg_mem_op}};
  assign dbg_adr     = oadr_q;
  assign dbg_do      = odo_q;
  assign busy        = (state_q != S_IDLE);
  assign cpu_n_reset = cpu_q;

endmodule

// File: tb/tb_dbg_loader.sv
// tb_dbg_loader: directed + randomized byte streams against a frame-level model.
// Timeout shortened through the parameter to keep runs short.
module tb_dbg_loader;
  localparam int WR  = 2;
  localparam int TMO = 40;
`ifdef DBG_LOADER_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cpu_n_reset;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic        busy;
  bit          rnd_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbg_loader #(.WR_CYCLES(WR), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .n_reset(n_reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_n_reset(cpu_n_reset), .dbg_mem_op(dbg_mem_op),
    .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: m_nb = bytes collected in current frame (-1 = none)
  int          m_nb = -1;
  int          m_idle = 0;
  int          m_wr = 0;
  bit          m_ack = 1'b0;
  bit          m_cpu = 1'b1;
  logic [31:0] m_adr = '0;
  logic [31:0] m_do = '0;
  logic [7:0]  m_frame [8];

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_nb = -1; m_idle = 0; m_wr = 0; m_ack = 1'b0;
      m_cpu = 1'b1; m_adr = '0; m_do = '0;
    end else if (m_wr > 0) begin
      m_wr--;
      if (m_wr == 0) m_ack = 1'b1;
    end else if (m_ack) begin
      if (!ECHO || tx_ready) m_ack = 1'b0;
    end else if (m_nb < 0) begin
      if (rx_valid) begin
        if (rx_data == 8'hA5) begin
          m_nb = 0; m_idle = 0; m_cpu = 1'b0;
        end else if (rx_data == 8'h5A) begin
          m_cpu = 1'b1; m_ack = 1'b1;
        end else if (rx_data == 8'hC3) begin
          m_cpu = 1'b0; m_ack = 1'b1;
        end
      end
    end else if (rx_valid) begin
      m_frame[m_nb] = rx_data;
      m_nb++;
      m_idle = 0;
      if (m_nb == 8) begin
        m_adr = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
        m_do  = {m_frame[7], m_frame[6], m_frame[5], m_frame[4]};
        m_wr  = WR;
        m_nb  = -1;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) m_nb = -1;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (m_nb >= 0) || (m_wr > 0) || m_ack);
    chk("mem_op", dbg_mem_op, m_wr > 0);
    chk("wren", dbg_wren, (m_wr > 0) ? 4'hF : 4'h0);
    chk("adr", dbg_adr, m_adr);
    chk("do", dbg_do, m_do);
    chk("cpu_n_reset", cpu_n_reset, m_cpu);
    chk("tx_valid", tx_valid, ECHO && m_ack);
    chk("tx_data", tx_data, (ECHO && m_ack) ? 8'h06 : 8'h00);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    idle(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
    send(8'hA5);
    for (int k = 0; k < 4; k++) send(a[8*k +: 8]);
    for (int k = 0; k < 4; k++) send(d[8*k +: 8]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      idle(1);
      n++;
    end
    chk("wait_idle_bound", busy, 1'b0);
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 92) return $urandom_range(0, 2);
    if (r < 94) return TMO - 1;
    if (r < 97) return TMO;
    return TMO + 3;
  endfunction

  initial begin
    int a;
    int g;
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu", cpu_n_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_adr", dbg_adr, 32'h0);
    n_reset = 1'b1;
    idle(1);

    // reference frame: write 0x000107B7 to 0x00020000
    send(8'hA5);
    chk("a5_cpu", cpu_n_reset, 1'b0);
    chk("a5_busy", busy, 1'b1);
    send(8'h00); send(8'h00); send(8'h02); send(8'h00);
    send(8'hB7); send(8'h07); send(8'h01); send(8'h00);
    chk("w1_memop", dbg_mem_op, 1'b1);
    chk("w1_wren", dbg_wren, 4'hF);
    chk("w1_adr", dbg_adr, 32'h00020000);
    chk("w1_do", dbg_do, 32'h000107B7);
    chk("model_adr", m_adr, 32'h00020000);
    chk("model_do", m_do, 32'h000107B7);
    idle(1);
    chk("w2_memop", dbg_mem_op, 1'b1);
    idle(1);
    chk("w_end_memop", dbg_mem_op, 1'b0);
    chk("w_end_busy", busy, 1'b1);
    wait_idle();
    send(8'h5A);
    chk("rel_cpu", cpu_n_reset, 1'b1);
    chk("rel_memop", dbg_mem_op, 1'b0);
    wait_idle();

    // timeout on a partial frame
    send(8'hA5); send(8'h00); send(8'h00); send(8'h02);
    idle(TMO - 1);
    chk("tmo_edge_busy", busy, 1'b1);
    idle(1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_cpu", cpu_n_reset, 1'b0);
    send(8'h5A);
    chk("tmo_rel_cpu", cpu_n_reset, 1'b1);
    wait_idle();

    // byte arriving on the timeout cycle is accepted
    send(8'hA5); send(8'h11);
    idle(TMO - 1);
    send(8'h22);
    chk("tmo_accept_busy", busy, 1'b1);
    idle(TMO);
    chk("tmo2_busy", busy, 1'b0);

    // async reset in the middle of WRITE
    send_frame(32'h1234_5678, 32'hCAFE_F00D);
    chk("pre_rst_memop", dbg_mem_op, 1'b1);
    #1 n_reset = 1'b0;
    #1;
    chk("arst_memop", dbg_mem_op, 1'b0);
    chk("arst_wren", dbg_wren, 4'h0);
    chk("arst_cpu", cpu_n_reset, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_adr", dbg_adr, 32'h0);
    #1 n_reset = 1'b1;
    idle(1);
    send(8'h00);
    chk("post_rst_busy", busy, 1'b0);

`ifdef DBG_LOADER_ECHO_EN
    tx_ready = 1'b0;
    send_frame(32'h0000_0100, 32'h0000_00AA);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      chk("echo_txv", tx_valid, 1'b1);
      chk("echo_txd", tx_data, 8'h06);
      chk("echo_busy", busy, 1'b1);
      if (i == 4) send(8'h5A);
      else idle(1);
    end
    chk("echo_drop_cpu", cpu_n_reset, 1'b0);
    tx_ready = 1'b1;
    idle(1);
    chk("echo_done_busy", busy, 1'b0);
    chk("echo_done_txv", tx_valid, 1'b0);
`endif

    // randomized traffic
    rnd_ready = 1'b1;
    for (int it = 0; it < 250; it++) begin
      a = $urandom_range(0, 9);
      if (a <= 4) begin
        send(8'hA5);
        for (int k = 0; k < 8; k++) begin
          g = pick_gap();
          idle(g);
          send(8'($urandom));
        end
        idle($urandom_range(0, 4));
      end else if (a == 5) begin
        send(8'h5A);
        idle($urandom_range(0, 3));
      end else if (a == 6) begin
        send(8'hC3);
        idle($urandom_range(0, 3));
      end else if (a == 7) begin
        send(8'($urandom));
      end else if (a == 8) begin
        idle($urandom_range(0, 5));
      end else begin
        #1 n_reset = 1'b0;
        #2 n_reset = 1'b1;
        idle(1);
      end
    end
    rnd_ready = 1'b0;
    tx_ready = 1'b1;
    idle(TMO + 10);
    chk("end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
